seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for a DIGITS-wide 7-segment display, fed by the stopwatch/clock BCD bus.
//  Scans one digit at a time with optional leading-zero blanking, hex mode, per-digit decimal points and blink.
//  Input is snapshotted once per frame, so a digit never shows a value torn between two input words.
//  Sits between the timekeeping counters and the board display pins.
// PARAMETERS
//  DIGITS        8      number of digits scanned; nibble i = bcd_in[4i+3:4i], digit 0 = least significant
//  CLK_DIV       50000  clocks each digit stays selected (>=2)
//  BLINK_FRAMES  64     frames per blink half-period (>=1)
// PORTS
//  clk         in   1         system clock, all logic on posedge
//  rst         in   1         synchronous reset, active-high
//  bcd_in      in   4*DIGITS  digit values
//  dp_in       in   DIGITS    decimal point per digit
//  blink_mask  in   DIGITS    1 = digit blinks
//  blank_lz    in   1         1 = blank leading zeros
//  hex_en      in   1         1 = show 10..15 as A b C d E F
//  seg_out     out  8         bit7 = dp, bit6..0 = g..a, active-high, registered
//  digit_sel   out  DIGITS    one-hot digit enable, active-high, registered
//  frame_tick  out  1         one-cycle pulse at start of each frame, registered
// BEHAVIOUR
//  - Reset (rst=1 at an edge): prescaler=0, index=0, blink count=0, blink phase=0, snapshot (bcd/dp/mask)=0;
//    seg_out=0, digit_sel=0, frame_tick=0. Mid-frame reset aborts the scan, restarts at digit 0.
//  - Prescaler counts 0..CLK_DIV-1 and wraps; at terminal count index advances, DIGITS-1 wraps to 0.
//  - Frame boundary = terminal count with index=DIGITS-1. On that edge:
//    snapshot <= {bcd_in, dp_in, blink_mask}; blink count advances.
//    At blink count BLINK_FRAMES-1 the count wraps to 0 and the blink phase toggles.
//  - Outputs are registered from current index/snapshot: one cycle latency.
//    First edge after reset release: digit_sel = 1<<0.
//    digit_sel changes exactly CLK_DIV cycles apart thereafter.
//    frame_tick = 1 in the same cycle digit_sel returns to bit 0 after a wrap; not asserted for the first frame after reset.
//  - Decode: 0..9 -> 3F 06 5B 4F 66 6D 7D 27 7F 6F.
//    10..15 -> 77 7C 39 5E 79 71 if hex_en, else 00 (blank).
//  - Leading-zero blank: digit i (i>0) shows segments 00 when blank_lz=1 and every snapshot nibble j>=i equals 0.
//    Digit 0 is never LZ-blanked. Nibbles 10..15 never count as zero.
//    dp still shown on an LZ-blanked digit.
//  - Blink: when blink phase=1 and snapshot mask bit i=1, seg_out=00 (dp included) for digit i.
//  - blank_lz and hex_en are sampled live, not snapshotted.
//  - Exactly one digit_sel bit is high at all times outside reset.
// STRUCTURE
//  - Shared include seg7_defs.vh: segment code localparams (SEG_0..SEG_9, SEG_A..SEG_F, SEG_BLANK) and the dp bit index;
//    reused by other display blocks.
//  - One sub-module: seg7_hex_decode (combinational, {nibble, hex_en} -> 7 seg bits).
//  - Top holds the prescaler, index, blink counter, snapshot, LZ-blank logic and output registers.
// TESTING (bench: DIGITS=8, CLK_DIV=4, BLINK_FRAMES=2)
//  1. Reset, blank_lz=1: hold rst 3 cycles -> outputs all 0.
//     Edge after release -> digit_sel=01, seg_out=3F; digits 1..7 seg_out=00 in first frame.
//  2. bcd_in=32'h12345678, blank_lz=0: digit_sel 01,02,..,80 each 4 cycles.
//     Digit0 7F, digit7 06; frame_tick every 32 cycles.
//  3. bcd_in=32'h00000405, dp_in=8'h04, blank_lz=1: digits 7..3 -> 00.
//     digit2 -> E6, digit1 -> 3F (inner zero shown), digit0 -> 6D.
//  4. bcd_in=32'h0000A000: hex_en=1 -> digit3=77, digits 2..0=3F.
//     hex_en=0 -> digit3=00, lower digits still 3F (A not a leading zero).
//  5. Change bcd_in from 32'h11111111 to 32'h22222222 mid-frame -> all digits show 06 until next frame_tick, then 5B.
//  6. blink_mask=8'h03, dp_in=8'h01: digits 0,1 lit 2 frames, dark (00, dp off) 2 frames; others steady.
//     Assert rst mid-frame -> next cycle outputs 0; scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_scan_driver_pkg.sv
// Shared 7-segment definitions: segment codes (g..a, active-high), dp bit index
// and a width helper used by the scan driver and its decoder.
package seg7_scan_driver_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h27;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam int         DP_BIT    = 7;

  // Counter width that stays at least one bit for degenerate parameter values.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to 7-segment decoder; 10..15 show as A b C d E F only
// when hex mode is enabled, otherwise they are blank.
module seg7_hex_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_en_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = hex_en_i ? SEG_A : SEG_BLANK;
      4'hB: seg_o = hex_en_i ? SEG_B : SEG_BLANK;
      4'hC: seg_o = hex_en_i ? SEG_C : SEG_BLANK;
      4'hD: seg_o = hex_en_i ? SEG_D : SEG_BLANK;
      4'hE: seg_o = hex_en_i ? SEG_E : SEG_BLANK;
      4'hF: seg_o = hex_en_i ? SEG_F : SEG_BLANK;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed DIGITS-wide 7-segment driver: per-frame input snapshot,
// leading-zero blanking, hex mode, decimal points and per-digit blink.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int CLK_DIV      = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  blank_lz,
  input  logic                  hex_en,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_tick
);

  localparam int CNT_W = clog2_min1(CLK_DIV);
  localparam int IDX_W = clog2_min1(DIGITS);
  localparam int BLK_W = clog2_min1(BLINK_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic                blk_ph_q, blk_ph_d;
  logic                started_q, started_d;
  logic [4*DIGITS-1:0] snap_bcd_q, snap_bcd_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0]   snap_mask_q, snap_mask_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                tick_q, tick_d;

  logic [3:0]          cur_nib;
  logic                cur_dp, cur_mask, cur_lz, zero_run;
  logic [DIGITS-1:0]   lz_vec;
  logic [6:0]          dec_seg;

  seg7_hex_decode u_dec (
    .nibble_i (cur_nib),
    .hex_en_i (hex_en),
    .seg_o    (dec_seg)
  );

  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    blk_cnt_d   = blk_cnt_q;
    blk_ph_d    = blk_ph_q;
    started_d   = started_q;
    snap_bcd_d  = snap_bcd_q;
    snap_dp_d   = snap_dp_q;
    snap_mask_d = snap_mask_q;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        // Frame boundary: take a coherent snapshot and advance the blink timer.
        idx_d       = '0;
        started_d   = 1'b1;
        snap_bcd_d  = bcd_in;
        snap_dp_d   = dp_in;
        snap_mask_d = blink_mask;
        if (blk_cnt_q == BLK_LAST) begin
          blk_cnt_d = '0;
          blk_ph_d  = ~blk_ph_q;
        end else begin
          blk_cnt_d = blk_cnt_q + BLK_W'(1);
        end
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    // lz_vec[i] is set when every snapshot nibble from i upward is zero.
    zero_run = 1'b1;
    lz_vec   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run  = zero_run && (snap_bcd_q[4*i +: 4] == 4'h0);
      lz_vec[i] = zero_run;
    end

    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_mask = 1'b0;
    cur_lz   = 1'b0;
    sel_d    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        cur_nib  = snap_bcd_q[4*i +: 4];
        cur_dp   = snap_dp_q[i];
        cur_mask = snap_mask_q[i];
        cur_lz   = (i != 0) && lz_vec[i];
        sel_d[i] = 1'b1;
      end else begin
        sel_d[i] = 1'b0;
      end
    end

    seg_d         = 8'h00;
    seg_d[DP_BIT] = cur_dp;
    if (blank_lz && cur_lz) begin
      seg_d[6:0] = SEG_BLANK;
    end else begin
      seg_d[6:0] = dec_seg;
    end
    if (blk_ph_q && cur_mask) begin
      seg_d = 8'h00;
    end else begin
      seg_d = seg_d;
    end

    tick_d = started_q && (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      blk_cnt_q   <= '0;
      blk_ph_q    <= 1'b0;
      started_q   <= 1'b0;
      snap_bcd_q  <= '0;
      snap_dp_q   <= '0;
      snap_mask_q <= '0;
      seg_q       <= 8'h00;
      sel_q       <= '0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      blk_cnt_q   <= blk_cnt_d;
      blk_ph_q    <= blk_ph_d;
      started_q   <= started_d;
      snap_bcd_q  <= snap_bcd_d;
      snap_dp_q   <= snap_dp_d;
      snap_mask_q <= snap_mask_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
      tick_q      <= tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign digit_sel  = sel_q;
  assign frame_tick = tick_q;

endmodule
